// File: rtl/seg7_scan_decoder.sv
// Receive-side decoder for a multiplexed active-low 7-segment bus: filters scan
// transitions, decodes each stable digit and reassembles full scans into frames.
module seg7_scan_decoder #(
  parameter int NDIG          = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [6:0]            seg,
  input  logic [NDIG-1:0]       an,
  output logic [4*NDIG-1:0]     hex_out,
  output logic [NDIG-1:0]       blank_out,
  output logic                  frame_done,
  output logic                  code_err
);

  localparam int CNT_W = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    WAIT_SYNC = 2'd0,
    COLLECT   = 2'd1,
    DONE      = 2'd2
  } state_t;

  // Returns {err, blank, value}; blank and err both force value to zero.
  function automatic logic [5:0] f_decode(input logic [6:0] s);
    case (s)
      7'h40:   return {2'b00, 4'h0};
      7'h79:   return {2'b00, 4'h1};
      7'h24:   return {2'b00, 4'h2};
      7'h30:   return {2'b00, 4'h3};
      7'h19:   return {2'b00, 4'h4};
      7'h12:   return {2'b00, 4'h5};
      7'h02:   return {2'b00, 4'h6};
      7'h78:   return {2'b00, 4'h7};
      7'h00:   return {2'b00, 4'h8};
      7'h10:   return {2'b00, 4'h9};
      7'h08:   return {2'b00, 4'hA};
      7'h03:   return {2'b00, 4'hB};
      7'h46:   return {2'b00, 4'hC};
      7'h21:   return {2'b00, 4'hD};
      7'h06:   return {2'b00, 4'hE};
      7'h0E:   return {2'b00, 4'hF};
      7'h7F:   return {2'b01, 4'h0};
      default: return {2'b11, 4'h0};
    endcase
  endfunction

  logic [6:0]         r_seg_p0, r_seg_p1;
  logic [NDIG-1:0]    r_an_p0, r_an_p1;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_captured;
  state_t             r_state;
  state_t             w_state_next;
  logic [NDIG-1:0]    r_mask;
  logic [4*NDIG-1:0]  r_dig;
  logic [NDIG-1:0]    r_blk;
  logic [4*NDIG-1:0]  r_hex;
  logic [NDIG-1:0]    r_blank;
  logic               r_code_err;

  logic               w_same;
  logic [NDIG-1:0]    w_an_act;
  logic               w_onehot;
  logic               w_capture;
  logic [5:0]         w_dec;
  logic               w_accept;
  logic               w_frame_done;
  logic [4*NDIG-1:0]  w_dig_next;
  logic [NDIG-1:0]    w_blk_next;
  logic [NDIG-1:0]    w_mask_next;

  // Stage p0/p1: two-flop synchronizer, idle (all-ones) out of reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_seg_p0 <= '1;
      r_seg_p1 <= '1;
      r_an_p0  <= '1;
      r_an_p1  <= '1;
    end else begin
      r_seg_p0 <= seg;
      r_seg_p1 <= r_seg_p0;
      r_an_p0  <= an;
      r_an_p1  <= r_an_p0;
    end
  end

  // The sample about to become current is compared with the current one, so a
  // change is seen one edge earlier than a separate history register would.
  assign w_same    = ({r_an_p0, r_seg_p0} == {r_an_p1, r_seg_p1});
  assign w_an_act  = ~r_an_p1;
  assign w_onehot  = ($countones(w_an_act) == 1);
  assign w_capture = w_same && (r_cnt == CNT_MAX) && !r_captured && w_onehot;
  assign w_dec     = f_decode(r_seg_p1);

  // Stability filter: saturating run-length counter, one capture per run
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt      <= '0;
      r_captured <= 1'b0;
    end else if (!w_same) begin
      r_cnt      <= '0;
      r_captured <= 1'b0;
    end else begin
      if (r_cnt != CNT_MAX) r_cnt <= CNT_W'(r_cnt + 1'b1);
      if (w_capture) r_captured <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= WAIT_SYNC;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      WAIT_SYNC: if (w_capture && w_an_act[0]) w_state_next = COLLECT;
      COLLECT:   if (w_capture && (&(r_mask | w_an_act))) w_state_next = DONE;
      DONE:      w_state_next = COLLECT;
      default:   w_state_next = WAIT_SYNC;
    endcase
  end

  // Until the first digit 0 is seen, captures of other digits are discarded
  always_comb begin
    w_accept     = 1'b0;
    w_frame_done = 1'b0;
    case (r_state)
      WAIT_SYNC: w_accept = w_capture && w_an_act[0];
      COLLECT:   w_accept = w_capture;
      DONE:      w_frame_done = 1'b1;
      default:   w_accept = 1'b0;
    endcase
  end

  always_comb begin
    w_dig_next = r_dig;
    w_blk_next = r_blk;
    for (int i = 0; i < NDIG; i++) begin
      if (w_accept && w_an_act[i]) begin
        w_dig_next[4*i +: 4] = w_dec[3:0];
        w_blk_next[i]        = w_dec[4];
      end
    end
  end

  always_comb begin
    w_mask_next = r_mask;
    if (r_state == DONE)  w_mask_next = '0;
    else if (w_accept)    w_mask_next = r_mask | w_an_act;
  end

  // Frame snapshot is taken on the final capture edge so it is already valid
  // while frame_done is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mask     <= '0;
      r_dig      <= '0;
      r_blk      <= '1;
      r_hex      <= '0;
      r_blank    <= '1;
      r_code_err <= 1'b0;
    end else begin
      r_mask     <= w_mask_next;
      r_dig      <= w_dig_next;
      r_blk      <= w_blk_next;
      r_code_err <= w_capture && w_dec[5];
      if ((r_state == COLLECT) && (w_state_next == DONE)) begin
        r_hex   <= w_dig_next;
        r_blank <= w_blk_next;
      end
    end
  end

  assign hex_out    = r_hex;
  assign blank_out  = r_blank;
  assign frame_done = w_frame_done;
  assign code_err   = r_code_err;

endmodule
